// File: rtl/fabric_port_pkg.sv
// fabric_port_pkg: widths and beat-ordering constants shared by the fabric-port TDM serializer and reassembler
package fabric_port_pkg;
  localparam int WIDTH_IN_DEF  = 4;
  localparam int WIDTH_OUT_DEF = 16;
  localparam bit BEAT0_LSB     = 1'b1;
  function automatic int ratio_of(input int width_in, input int width_out);
    return width_out / width_in;
  endfunction
endpackage

// File: rtl/detdm.sv
// detdm: collects RATIO narrow beats (beat 0 = LSB slice) into one wide word on a registered valid/ready output
module detdm
  import fabric_port_pkg::*;
#(
  parameter int WIDTH_IN  = WIDTH_IN_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF,
  parameter int RATIO     = ratio_of(WIDTH_IN, WIDTH_OUT),
  localparam int CW       = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_IN-1:0]  i_data_in,
  input  logic                 i_valid_in,
  output logic                 i_ready_out,
  output logic [WIDTH_OUT-1:0] o_data_out,
  output logic                 o_valid_out,
  input  logic                 o_ready_in,
  output logic [CW-1:0]        o_beat_cnt
);
  localparam int AW = (RATIO - 1) * WIDTH_IN;
  if (WIDTH_OUT != RATIO * WIDTH_IN || RATIO < 2 || !BEAT0_LSB) begin : g_bad_cfg
    $error("detdm: WIDTH_OUT must be an exact multiple (>=2x) of WIDTH_IN with beat 0 in the LSB slice");
  end
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        asm_q, asm_d;
  logic [WIDTH_OUT-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last, acc, fin;
  // Only the final beat can stall, and only when the output slot is full and not draining
  assign last        = cnt_q == CW'(RATIO - 1);
  assign i_ready_out = rst & (~last | ~valid_q | o_ready_in);
  assign acc         = i_valid_in & i_ready_out;
  assign fin         = acc & last;
  assign o_data_out  = data_q;
  assign o_valid_out = valid_q;
  assign o_beat_cnt  = cnt_q;
  // Next-state: advance the beat index and drop non-final beats into their slice
  always_comb begin
    cnt_d = acc ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    asm_d = asm_q;
    if (acc && !last) asm_d[int'(cnt_q) * WIDTH_IN +: WIDTH_IN] = i_data_in;
    data_d  = fin ? {i_data_in, asm_q} : data_q;
    valid_d = fin | (valid_q & ~o_ready_in);
  end
  // Beat counter and partial-word assembly; reset discards any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end
  // Output slot: loads on the final beat, holds while stalled, empties on a drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_detdm.sv
// tb_detdm: directed and random stimulus for detdm checked against a word-level reference model
module tb_detdm;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  i_data_in = '0;
  logic        i_valid_in = 1'b0;
  logic        i_ready_out;
  logic [15:0] o_data_out;
  logic        o_valid_out;
  logic        o_ready_in = 1'b0;
  logic [1:0]  o_beat_cnt;
  int errors = 0;
  int checks = 0;
  int          idx = 0;
  logic [15:0] part = '0;
  logic        mv = 1'b0;
  logic [15:0] md = '0;

  detdm dut (
    .clk(clk), .rst(rst),
    .i_data_in(i_data_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
    .o_data_out(o_data_out), .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
    .o_beat_cnt(o_beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic r);
    logic rdy;
    logic acc;
    @(negedge clk);
    i_valid_in = v;
    i_data_in  = v ? d : 4'hx;
    o_ready_in = r;
    #1;
    rdy = (idx != 3) || !mv || r;
    chk("i_ready_out", {31'd0, i_ready_out}, {31'd0, rdy});
    acc = v && rdy;
    @(posedge clk);
    if (mv && r) mv = 1'b0;
    if (acc) begin
      part = part | (16'(d) << (4 * idx));
      if (idx == 3) begin
        mv = 1'b1;
        md = part;
        part = '0;
        idx = 0;
      end else idx++;
    end
    #1;
    chk("o_valid_out", {31'd0, o_valid_out}, {31'd0, mv});
    if (mv) chk("o_data_out", {16'd0, o_data_out}, {16'd0, md});
    chk("o_beat_cnt", {30'd0, o_beat_cnt}, idx);
  endtask

  task automatic word(input logic [15:0] w, input logic r);
    for (int k = 0; k < 4; k++) step(1'b1, w[4*k +: 4], r);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    i_valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    idx = 0; part = '0; mv = 1'b0; md = '0;
    chk("rst o_valid_out", {31'd0, o_valid_out}, 32'd0);
    chk("rst o_data_out", {16'd0, o_data_out}, 32'd0);
    chk("rst o_beat_cnt", {30'd0, o_beat_cnt}, 32'd0);
    chk("rst i_ready_out", {31'd0, i_ready_out}, 32'd0);
    #1 rst = 1'b1;
  endtask

  initial begin
    #3;
    chk("por o_valid_out", {31'd0, o_valid_out}, 32'd0);
    chk("por o_data_out", {16'd0, o_data_out}, 32'd0);
    chk("por o_beat_cnt", {30'd0, o_beat_cnt}, 32'd0);
    chk("por i_ready_out", {31'd0, i_ready_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post-reset i_ready_out", {31'd0, i_ready_out}, 32'd1);
    word(16'hABCD, 1'b1);
    chk("basic word", {16'd0, o_data_out}, 32'h0000ABCD);
    step(1'b0, 4'h0, 1'b1);
    chk("basic single-cycle valid", {31'd0, o_valid_out}, 32'd0);
    word(16'h1234, 1'b1);
    chk("b2b first", {16'd0, o_data_out}, 32'h00001234);
    word(16'h5678, 1'b1);
    chk("b2b second", {16'd0, o_data_out}, 32'h00005678);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'hD, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'hC, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'hB, 1'b1);
    step(1'b1, 4'hA, 1'b1);
    chk("gaps word", {16'd0, o_data_out}, 32'h0000ABCD);
    step(1'b0, 4'h0, 1'b1);
    word(16'hABCD, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    chk("bp stall ready", {31'd0, i_ready_out}, 32'd0);
    chk("bp hold data", {16'd0, o_data_out}, 32'h0000ABCD);
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h1, 1'b1);
    chk("bp release word", {16'd0, o_data_out}, 32'h00001234);
    step(1'b0, 4'h0, 1'b1);
    word(16'hABCD, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    step(1'b1, 4'h5, 1'b1);
    chk("drain+final valid", {31'd0, o_valid_out}, 32'd1);
    chk("drain+final data", {16'd0, o_data_out}, 32'h00005678);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'hD, 1'b1);
    step(1'b1, 4'hC, 1'b1);
    pulse_reset();
    word(16'h1234, 1'b1);
    chk("post-reset word", {16'd0, o_data_out}, 32'h00001234);
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/detdm.md
Name: detdm

Overview:
- Narrow-to-wide reassembler, the downstream stage of the fabric-port TDM serializer.
- Collects RATIO consecutive narrow beats (WIDTH_IN bits each) from the serializer's output handshake.
- Presents each completed beat group as one wide word (WIDTH_OUT bits) on a registered valid/ready output.
- Runs entirely in the fast (NoC-side) clock domain.

Parameters:
- WIDTH_IN, 4: narrow beat width in bits.
- WIDTH_OUT, 16: reassembled word width in bits.
- RATIO, WIDTH_OUT/WIDTH_IN: beats per word. WIDTH_OUT must be an exact multiple of WIDTH_IN, and RATIO must be ≥2. Elaboration-time assertion fails otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted while rst=0).
- i_data_in  input  WIDTH_IN  narrow beat.
- i_valid_in  input  1  beat valid.
- i_ready_out  output  1  beat accepted when i_valid_in & i_ready_out at the clk edge.
- o_data_out  output  WIDTH_OUT  reassembled word.
- o_valid_out  output  1  word valid.
- o_ready_in  input  1  downstream accepts the word when o_valid_out & o_ready_in at the clk edge.
- o_beat_cnt  output  clog2(RATIO)  current assembly index (debug/verification).

Behaviour:
- Reset (rst=0, async):
  - beat_cnt=0, asm_reg=0, o_data_out=0, o_valid_out=0.
  - i_ready_out=1 once rst deasserts. It reads 0 while rst=0.
  - Reset mid-word discards any partial beats. The next accepted beat is treated as beat 0.
- Beat ordering is fixed: beat k lands in bits [(k+1)*WIDTH_IN-1 : k*WIDTH_IN]. Beat 0 is the least-significant slice.
- Internal state:
  - beat_cnt: counts 0..RATIO-1 and wraps to 0 after the final beat.
  - asm_reg: holds beats 0..RATIO-2.
  - out_reg: holds o_data_out and o_valid_out.
- i_ready_out (combinational) = (beat_cnt != RATIO-1) | ~o_valid_out | o_ready_in.
  - Non-final beats are always accepted.
  - The final beat is accepted only if the output slot is empty or drains on the same edge.
- On an accepted non-final beat: asm_reg slice[beat_cnt] <= i_data_in; beat_cnt++.
- On an accepted final beat (beat_cnt==RATIO-1):
  - o_data_out <= {i_data_in, asm_reg[lower RATIO-1 slices]}.
  - o_valid_out <= 1; beat_cnt <= 0.
- Latency: the final beat accepted at edge N gives o_valid_out=1 and a valid o_data_out after edge N, i.e. visible in cycle N+1. Full throughput is one word per RATIO cycles with no bubbles.
- Output handshake:
  - o_valid_out and o_data_out are held stable while o_valid_out & ~o_ready_in.
  - On a handshake with no new final beat, o_valid_out <= 0. o_data_out may hold its stale value.
- Simultaneous drain + final beat on the same edge: o_valid_out stays 1 and o_data_out loads the new word. No bubble, no loss.
- Backpressure while assembling: beats 0..RATIO-2 of the next word continue to fill asm_reg while the previous word is stalled. Only the final beat is stalled.
- i_valid_in=0 cycles mid-word: beat_cnt and asm_reg hold. Gaps between beats are legal.
- i_data_in is don't-care when i_valid_in=0. X/Z on i_data_in must not propagate into state in that case.

Decomposition:
- Shared package fabric_port_pkg:
  - default WIDTH_IN/WIDTH_OUT constants shared with the serializer.
  - RATIO derivation function.
  - beat-ordering constant BEAT0_LSB=1.
- No sub-module; a single module with one always_ff block for the counter/assembly and one for the output register.

Test Plan (WIDTH_IN=4, WIDTH_OUT=16):
- Basic: release reset, drive beats D,C,B,A on 4 consecutive cycles with o_ready_in=1. Required: 16'hABCD with o_valid_out=1 for exactly one cycle, in the cycle after beat A; o_beat_cnt returns to 0.
- Back-to-back: beats 4,3,2,1,8,7,6,5 continuous with o_ready_in=1. Required: 16'h1234 then, 4 cycles later, 16'h5678; i_ready_out stays 1 throughout.
- Gaps: beats D,_,C,_,_,B,A with i_valid_in low in the gaps. Required: 16'hABCD once, 1 cycle after A; no spurious valid.
- Backpressure: o_ready_in=0, send word 16'hABCD then beats 4,3,2,1. Required: o_data_out holds 16'hABCD; i_ready_out=0 only while beat 1 is presented. Raising o_ready_in gives 16'hABCD accepted then 16'h1234 on the next cycle.
- Simultaneous drain and final beat: o_valid_out=1 with 16'hABCD, o_ready_in=1 on the same edge as the final beat of 16'h5678. Required: o_valid_out stays 1 and the next cycle shows 16'h5678.
- Async reset mid-word: after beats D,C, pulse rst=0 between clock edges. Required: outputs 0 immediately, o_beat_cnt=0; then beats 4,3,2,1 give 16'h1234.
